// File: rtl/svo_tmds.sv
// TMDS encoder stage of the SVO video pipeline.
// Turns the timed RGB stream into three DC-balanced 10-bit symbols per clock.
module svo_tmds #(
  parameter int SVO_BITS_PER_PIXEL  = 24,
  parameter int SVO_HSYNC_ACTIVE_HI = 1,
  parameter int SVO_VSYNC_ACTIVE_HI = 1
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          in_axis_tvalid,
  output logic                          in_axis_tready,
  input  logic [SVO_BITS_PER_PIXEL-1:0] in_axis_tdata,
  input  logic [3:0]                    in_axis_tuser,
  output logic [9:0]                    tmds_d0,
  output logic [9:0]                    tmds_d1,
  output logic [9:0]                    tmds_d2,
  output logic                          out_sof,
  output logic                          underrun
);

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  localparam logic HS_INV = (SVO_HSYNC_ACTIVE_HI == 0);
  localparam logic VS_INV = (SVO_VSYNC_ACTIVE_HI == 0);

  // transition-minimising first half of the TMDS code
  function automatic logic [8:0] qm_enc(input logic [7:0] d);
    logic [3:0] n;
    logic       use_xnor;
    logic [8:0] q;
    n = '0;
    q = '0;
    for (int i = 0; i < 8; i++) n = n + 4'(d[i]);
    use_xnor = (n > 4'd4) || ((n == 4'd4) && !d[0]);
    q[0] = d[0];
    for (int i = 1; i < 8; i++)
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~use_xnor;
    return q;
  endfunction

  // DC-balancing second half; returns {next cnt, symbol}
  function automatic logic [14:0] tmds_word(
    input logic        [8:0] qm,
    input logic signed [4:0] cnt
  );
    logic        [3:0] n1;
    logic        [3:0] n0;
    logic signed [4:0] n1s;
    logic signed [4:0] n0s;
    logic signed [4:0] two;
    logic signed [4:0] nxt;
    logic        [9:0] q;
    n1 = '0;
    for (int i = 0; i < 8; i++) n1 = n1 + 4'(qm[i]);
    n0  = 4'd8 - n1;
    n1s = $signed({1'b0, n1});
    n0s = $signed({1'b0, n0});
    if ((cnt == 5'sd0) || (n1 == n0)) begin
      q   = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      nxt = qm[8] ? (cnt + n1s - n0s) : (cnt + n0s - n1s);
    end else if ((!cnt[4] && (n1 > n0)) || (cnt[4] && (n1 < n0))) begin
      two = qm[8] ? 5'sd2 : 5'sd0;
      q   = {1'b1, qm[8], ~qm[7:0]};
      nxt = cnt + two + n0s - n1s;
    end else begin
      two = qm[8] ? 5'sd0 : 5'sd2;
      q   = {1'b0, qm[8], qm[7:0]};
      nxt = cnt - two + n1s - n0s;
    end
    return {nxt, q};
  endfunction

  function automatic logic [9:0] ctrl_code(input logic [1:0] c);
    logic [9:0] s;
    case (c)
      2'b00:   s = CTRL_00;
      2'b01:   s = CTRL_01;
      2'b10:   s = CTRL_10;
      default: s = CTRL_11;
    endcase
    return s;
  endfunction

  logic        ready;
  logic        und;
  logic [23:0] s0_data;
  logic        s0_blank;
  logic        s0_c0;
  logic        s0_c1;
  logic        s0_sof;
  logic        last_hs;
  logic        last_vs;

  logic [8:0]  s1_qm0;
  logic [8:0]  s1_qm1;
  logic [8:0]  s1_qm2;
  logic        s1_blank;
  logic        s1_c0;
  logic        s1_c1;
  logic        s1_sof;

  logic signed [4:0] cnt0;
  logic signed [4:0] cnt1;
  logic signed [4:0] cnt2;
  logic signed [4:0] w0_cnt;
  logic signed [4:0] w1_cnt;
  logic signed [4:0] w2_cnt;
  logic        [9:0] w0_sym;
  logic        [9:0] w1_sym;
  logic        [9:0] w2_sym;

  logic [9:0] d0_r;
  logic [9:0] d1_r;
  logic [9:0] d2_r;
  logic       sof_r;

  assign in_axis_tready = ready;
  assign underrun       = und;
  assign tmds_d0        = d0_r;
  assign tmds_d1        = d1_r;
  assign tmds_d2        = d2_r;
  assign out_sof        = sof_r;

  // input slot: accept a beat or substitute a blank one on starvation
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready    <= 1'b0;
      und      <= 1'b0;
      s0_data  <= '0;
      s0_blank <= 1'b1;
      s0_c0    <= 1'b0;
      s0_c1    <= 1'b0;
      s0_sof   <= 1'b0;
      last_hs  <= 1'b0;
      last_vs  <= 1'b0;
    end else begin
      ready <= 1'b1;
      if (ready && in_axis_tvalid) begin
        s0_data  <= in_axis_tdata[23:0];
        s0_blank <= in_axis_tuser[3];
        s0_c0    <= in_axis_tuser[1] ^ HS_INV;
        s0_c1    <= in_axis_tuser[2] ^ VS_INV;
        s0_sof   <= in_axis_tuser[0];
        last_hs  <= in_axis_tuser[1];
        last_vs  <= in_axis_tuser[2];
      end else begin
        s0_blank <= 1'b1;
        s0_c0    <= last_hs ^ HS_INV;
        s0_c1    <= last_vs ^ VS_INV;
        s0_sof   <= 1'b0;
        if (ready) und <= 1'b1;
      end
    end
  end

  // stage 1: q_m per channel and flag pass-through
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_qm0   <= '0;
      s1_qm1   <= '0;
      s1_qm2   <= '0;
      s1_blank <= 1'b1;
      s1_c0    <= 1'b0;
      s1_c1    <= 1'b0;
      s1_sof   <= 1'b0;
    end else begin
      s1_qm0   <= qm_enc(s0_data[23:16]);
      s1_qm1   <= qm_enc(s0_data[15:8]);
      s1_qm2   <= qm_enc(s0_data[7:0]);
      s1_blank <= s0_blank;
      s1_c0    <= s0_c0;
      s1_c1    <= s0_c1;
      s1_sof   <= s0_sof;
    end
  end

  // disparity-balanced symbol and next counter per channel
  always_comb begin
    {w0_cnt, w0_sym} = tmds_word(s1_qm0, cnt0);
    {w1_cnt, w1_sym} = tmds_word(s1_qm1, cnt1);
    {w2_cnt, w2_sym} = tmds_word(s1_qm2, cnt2);
  end

  // stage 2: output symbols, control slots clear disparity
  always_ff @(posedge clk) begin
    if (!resetn) begin
      d0_r  <= CTRL_00;
      d1_r  <= CTRL_00;
      d2_r  <= CTRL_00;
      cnt0  <= '0;
      cnt1  <= '0;
      cnt2  <= '0;
      sof_r <= 1'b0;
    end else begin
      sof_r <= s1_sof;
      if (s1_blank) begin
        d0_r <= ctrl_code({s1_c1, s1_c0});
        d1_r <= CTRL_00;
        d2_r <= CTRL_00;
        cnt0 <= '0;
        cnt1 <= '0;
        cnt2 <= '0;
      end else begin
        d0_r <= w0_sym;
        d1_r <= w1_sym;
        d2_r <= w2_sym;
        cnt0 <= w0_cnt;
        cnt1 <= w1_cnt;
        cnt2 <= w2_cnt;
      end
    end
  end

endmodule

// File: tb/tb_svo_tmds.sv
// Bench for svo_tmds: directed vector table, underrun/reset
// sequences and a long random stream against a reference encoder.
module tb_svo_tmds;

  logic        clk = 1'b0;
  logic        resetn;
  logic        tvalid;
  logic        tready;
  logic [23:0] tdata;
  logic [3:0]  tuser;
  logic [9:0]  d0;
  logic [9:0]  d1;
  logic [9:0]  d2;
  logic        sof;
  logic        und;

  always #5 clk = ~clk;

  svo_tmds dut (
    .clk            (clk),
    .resetn         (resetn),
    .in_axis_tvalid (tvalid),
    .in_axis_tready (tready),
    .in_axis_tdata  (tdata),
    .in_axis_tuser  (tuser),
    .tmds_d0        (d0),
    .tmds_d1        (d1),
    .tmds_d2        (d2),
    .out_sof        (sof),
    .underrun       (und)
  );

  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] C01 = 10'b0010101011;
  localparam logic [9:0] C10 = 10'b0101010100;
  localparam logic [9:0] C11 = 10'b1010101011;
  localparam logic [9:0] Q0  = 10'b0100000000;
  localparam logic [9:0] QF  = 10'b1111111111;
  localparam logic [9:0] FFC = 10'b1000000000;

  typedef struct {
    logic        valid;
    logic [23:0] data;
    logic [3:0]  user;
    logic [9:0]  x0;
    logic [9:0]  x1;
    logic [9:0]  x2;
    logic        xsof;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [9:0] e_sym [3][3];
  logic       e_sof [3];
  int         cnt_m [3];
  int         dut_disp [3];
  bit         rdy_m;
  bit         und_m;
  logic [1:0] last_m;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] ctrl_code(input logic [1:0] c);
    logic [9:0] t [4];
    t[0] = C00; t[1] = C01; t[2] = C10; t[3] = C11;
    return t[c];
  endfunction

  // Reference: cnt is the running (ones - zeros) of every bit sent.
  function automatic logic [9:0] enc_data(input logic [7:0] d,
                                          inout int cnt);
    int         nd;
    int         n1;
    bit         xn;
    bit         inv;
    logic [8:0] qm;
    logic [9:0] s;
    nd = $countones(d);
    xn = (nd > 4) || (nd == 4 && d[0] == 1'b0);
    qm = '0;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++)
      qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !xn;
    n1 = $countones(qm[7:0]);
    if (cnt == 0 || n1 == 4) inv = !qm[8];
    else inv = ((cnt > 0) == (n1 > 4));
    s = {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
    cnt = cnt + 2 * $countones(s) - 10;
    return s;
  endfunction

  function automatic bit is_ctrl(input logic [9:0] s);
    return (s == C00) || (s == C01) || (s == C10) || (s == C11);
  endfunction

  task automatic step();
    logic       blank;
    logic       s_sof;
    logic [1:0] c;
    logic [23:0] pix;
    logic [9:0] o [3];
    bit         ok;
    @(posedge clk);
    if (!resetn) begin
      for (int s = 0; s < 3; s++) begin
        for (int k = 0; k < 3; k++) e_sym[s][k] = C00;
        e_sof[s] = 1'b0;
      end
      for (int k = 0; k < 3; k++) cnt_m[k] = 0;
      rdy_m = 0;
      und_m = 0;
      last_m = 2'b00;
    end else begin
      for (int k = 0; k < 3; k++) begin
        e_sym[2][k] = e_sym[1][k];
        e_sym[1][k] = e_sym[0][k];
      end
      e_sof[2] = e_sof[1];
      e_sof[1] = e_sof[0];
      if (rdy_m && tvalid) begin
        blank  = tuser[3];
        c      = {tuser[2], tuser[1]};
        s_sof  = tuser[0];
        pix    = tdata;
        last_m = c;
      end else begin
        blank = 1'b1;
        c     = last_m;
        s_sof = 1'b0;
        pix   = '0;
        if (rdy_m) und_m = 1;
      end
      if (blank) begin
        e_sym[0][0] = ctrl_code(c);
        e_sym[0][1] = C00;
        e_sym[0][2] = C00;
        for (int k = 0; k < 3; k++) cnt_m[k] = 0;
      end else begin
        e_sym[0][0] = enc_data(pix[23:16], cnt_m[0]);
        e_sym[0][1] = enc_data(pix[15:8], cnt_m[1]);
        e_sym[0][2] = enc_data(pix[7:0], cnt_m[2]);
      end
      e_sof[0] = s_sof;
      rdy_m = 1;
    end
    #1;
    chk("tready", tready, rdy_m);
    chk("underrun", und, und_m);
    chk("out_sof", sof, e_sof[2]);
    chk("tmds_d0", d0, e_sym[2][0]);
    chk("tmds_d1", d1, e_sym[2][1]);
    chk("tmds_d2", d2, e_sym[2][2]);
    o[0] = d0; o[1] = d1; o[2] = d2;
    ok = 1;
    for (int k = 0; k < 3; k++) begin
      if (!resetn || is_ctrl(o[k])) dut_disp[k] = 0;
      else dut_disp[k] = dut_disp[k] + 2 * $countones(o[k]) - 10;
      if (dut_disp[k] < -16 || dut_disp[k] > 15) ok = 0;
    end
    chk("disparity_bound", 32'(ok), 32'd1);
  endtask

  vec_t tbl [11];

  initial begin
    tbl[0]  = '{1'b1, 24'h0,      4'b1000, C00, C00, C00, 1'b0};
    tbl[1]  = '{1'b1, 24'h0,      4'b1010, C01, C00, C00, 1'b0};
    tbl[2]  = '{1'b1, 24'h0,      4'b1100, C10, C00, C00, 1'b0};
    tbl[3]  = '{1'b1, 24'h0,      4'b1110, C11, C00, C00, 1'b0};
    tbl[4]  = '{1'b1, 24'h0,      4'b0000, Q0,  Q0,  Q0,  1'b0};
    tbl[5]  = '{1'b1, 24'h0,      4'b0000, QF,  QF,  QF,  1'b0};
    tbl[6]  = '{1'b1, 24'h0,      4'b0000, Q0,  Q0,  Q0,  1'b0};
    tbl[7]  = '{1'b1, 24'h0,      4'b1000, C00, C00, C00, 1'b0};
    tbl[8]  = '{1'b1, 24'h0000FF, 4'b0001, Q0,  Q0,  FFC, 1'b1};
    tbl[9]  = '{1'b1, 24'h0,      4'b1000, C00, C00, C00, 1'b0};
    tbl[10] = '{1'b1, 24'h0,      4'b1000, C00, C00, C00, 1'b0};

    for (int k = 0; k < 3; k++) dut_disp[k] = 0;
    resetn = 1'b0;
    tvalid = 1'b0;
    tdata  = '0;
    tuser  = 4'b1000;

    // reset held for 4 clocks
    for (int i = 0; i < 4; i++) begin
      step();
      chk("reset_tready", tready, 0);
      chk("reset_d0", d0, C00);
    end
    resetn = 1'b1;
    tvalid = 1'b1;
    step();
    chk("tready_rise", tready, 1);
    chk("post_reset_d2", d2, C00);

    // directed vector table, outputs lag inputs by two steps
    for (int i = 0; i < 13; i++) begin
      if (i < 11) begin
        tvalid = tbl[i].valid;
        tdata  = tbl[i].data;
        tuser  = tbl[i].user;
      end else begin
        tvalid = 1'b1;
        tdata  = '0;
        tuser  = 4'b1000;
      end
      step();
      if (i >= 2) begin
        chk("tbl_d0", d0, tbl[i-2].x0);
        chk("tbl_d1", d1, tbl[i-2].x1);
        chk("tbl_d2", d2, tbl[i-2].x2);
        chk("tbl_sof", sof, tbl[i-2].xsof);
      end
    end

    // underrun after an active beat with hsync high
    tvalid = 1'b1;
    tdata  = 24'h123456;
    tuser  = 4'b0010;
    step();
    tvalid = 1'b0;
    step();
    chk("underrun_set", und, 1);
    tvalid = 1'b1;
    tdata  = 24'h654321;
    step();
    step();
    chk("underrun_slot_d0", d0, C01);
    chk("underrun_slot_d1", d1, C00);
    chk("underrun_slot_sof", sof, 0);
    for (int i = 0; i < 4; i++) step();
    chk("underrun_sticky", und, 1);
    resetn = 1'b0;
    step();
    chk("underrun_cleared", und, 0);
    chk("midreset_d0", d0, C00);
    resetn = 1'b1;
    step();

    // random stream
    for (int i = 0; i < 10000; i++) begin
      resetn = (i != 5000);
      tvalid = ($urandom_range(0, 29) != 0);
      tuser[3]   = ($urandom_range(0, 3) == 0);
      tuser[2:1] = 2'($urandom_range(0, 3));
      tuser[0]   = ($urandom_range(0, 63) == 0);
      case ($urandom_range(0, 5))
        0: tdata = 24'h000000;
        1: tdata = 24'hFFFFFF;
        default: tdata = 24'($urandom);
      endcase
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
